// File: rtl/conv_pool_engine.sv
// Programmable 3x3 conv (bias, shift, ReLU, saturate) with 2x2/stride-2 max/avg pooling.
// Every output is registered one cycle behind the state that produces it.
module conv_pool_engine #(
    parameter int IMG_W = 128,
    parameter int IMG_H = 128,
    parameter int PIX_W = 8,
    parameter int WT_W  = 8,
    parameter int OUT_W = 12,
    parameter int ACC_W = 24,
    parameter int SHIFT = 0,
    parameter int WBASE = 0
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  ready,
    input  logic                                  pool_avg,
    output logic                                  busy,
    output logic                                  done,
    output logic [$clog2(IMG_W*IMG_H)-1:0]        iaddr,
    output logic                                  ioe,
    input  logic [PIX_W-1:0]                      idata,
    output logic                                  oe_weight,
    output logic [15:0]                           addr_weight,
    input  logic [WT_W-1:0]                       r_data_weight,
    output logic                                  wen_L0,
    output logic [$clog2(IMG_W*IMG_H)-1:0]        addr_L0,
    output logic [OUT_W-1:0]                      w_data_L0,
    output logic                                  wen_L1,
    output logic [$clog2(IMG_W*IMG_H/4)-1:0]      addr_L1,
    output logic [OUT_W-1:0]                      w_data_L1
);
    localparam int CW  = $clog2(IMG_W);
    localparam int RW  = $clog2(IMG_H);
    localparam int AW  = CW + RW;
    localparam int PCW = CW - 1;
    localparam int PRW = RW - 1;
    localparam int L1W = PCW + PRW;
    localparam logic signed [ACC_W-1:0] MAXV = ACC_W'((1 << OUT_W) - 1);

    typedef enum logic [2:0] {S_IDLE, S_LOADK, S_TAP, S_ACC, S_WR, S_DONE} state_t;

    state_t                   r_state, w_state_nx;
    logic [3:0]               r_cnt;
    logic [PRW-1:0]           r_prow;
    logic [PCW-1:0]           r_pcol;
    logic [1:0]               r_sub;
    logic                     r_avg;
    logic signed [WT_W-1:0]   r_w [0:9];
    logic signed [ACC_W-1:0]  r_acc;
    logic [OUT_W+1:0]         r_pool;
    logic [3:0]               r_wk1, r_wk2, r_tk1, r_tk2;
    logic                     r_wv2, r_tv;

    logic [RW-1:0]            w_row, w_nrow;
    logic [CW-1:0]            w_col, w_ncol;
    logic [1:0]               w_dy, w_dx;
    logic                     w_inb, w_last;
    logic signed [PIX_W+WT_W:0] w_prod;
    logic signed [ACC_W-1:0]  w_tap_add, w_bias, w_sum, w_shift;
    logic [OUT_W-1:0]         w_clip, w_l1_data;
    logic [OUT_W+1:0]         w_pool_nx;

    logic                     w_busy_nx, w_done_nx, w_ioe_nx, w_oew_nx, w_wen0_nx, w_wen1_nx;
    logic [AW-1:0]            w_iaddr_nx, w_addr0_nx;
    logic [15:0]              w_addrw_nx;
    logic [OUT_W-1:0]         w_data0_nx, w_data1_nx;
    logic [L1W-1:0]           w_addr1_nx;

    assign w_row  = {r_prow, r_sub[1]};
    assign w_col  = {r_pcol, r_sub[0]};
    assign w_last = (r_sub == 2'd3) && (r_pcol == PCW'(IMG_W/2 - 1)) && (r_prow == PRW'(IMG_H/2 - 1));

    always_comb begin
        w_dy = 2'd0;
        w_dx = 2'd0;
        case (r_cnt)
            4'd1: w_dx = 2'd1;
            4'd2: w_dx = 2'd2;
            4'd3: w_dy = 2'd1;
            4'd4: begin w_dy = 2'd1; w_dx = 2'd1; end
            4'd5: begin w_dy = 2'd1; w_dx = 2'd2; end
            4'd6: w_dy = 2'd2;
            4'd7: begin w_dy = 2'd2; w_dx = 2'd1; end
            4'd8: begin w_dy = 2'd2; w_dx = 2'd2; end
            default: ;
        endcase
    end

    // Out-of-range neighbours wrap in the address but are masked by w_inb.
    assign w_nrow = w_row + RW'(w_dy) - RW'(1);
    assign w_ncol = w_col + CW'(w_dx) - CW'(1);
    assign w_inb  = !((w_dy == 2'd0) && (w_row == '0)) && !((w_dy == 2'd2) && (w_row == RW'(IMG_H - 1)))
                 && !((w_dx == 2'd0) && (w_col == '0)) && !((w_dx == 2'd2) && (w_col == CW'(IMG_W - 1)));

    assign w_prod    = $signed({1'b0, idata}) * r_w[r_tk2];
    assign w_tap_add = r_tv ? ACC_W'(w_prod) : '0;
    assign w_bias    = ACC_W'(r_w[9]);
    // Tap 8's data lands during WR, so the final sum folds in the live product.
    assign w_sum     = r_acc + w_tap_add + w_bias;
    assign w_shift   = w_sum >>> SHIFT;

    always_comb begin
        if (w_shift < 0)
            w_clip = '0;
        else if (w_shift > MAXV)
            w_clip = '1;
        else
            w_clip = w_shift[OUT_W-1:0];
    end

    always_comb begin
        if (r_avg)
            w_pool_nx = r_pool + {2'b00, w_clip};
        else
            w_pool_nx = ({2'b00, w_clip} > r_pool) ? {2'b00, w_clip} : r_pool;
        w_l1_data = r_avg ? w_pool_nx[OUT_W+1:2] : w_pool_nx[OUT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE:  if (ready) w_state_nx = S_LOADK;
            S_LOADK: if (r_cnt == 4'd10) w_state_nx = S_TAP;
            S_TAP:   if (r_cnt == 4'd8) w_state_nx = S_ACC;
            S_ACC:   w_state_nx = S_WR;
            S_WR:    w_state_nx = w_last ? S_DONE : S_TAP;
            S_DONE:  w_state_nx = S_IDLE;
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        w_busy_nx  = 1'b0;
        w_done_nx  = 1'b0;
        w_ioe_nx   = 1'b0;
        w_iaddr_nx = '0;
        w_oew_nx   = 1'b0;
        w_addrw_nx = '0;
        w_wen0_nx  = 1'b0;
        w_addr0_nx = '0;
        w_data0_nx = '0;
        w_wen1_nx  = 1'b0;
        w_addr1_nx = '0;
        w_data1_nx = '0;
        case (r_state)
            S_LOADK: begin
                w_busy_nx = 1'b1;
                if (r_cnt <= 4'd9) begin
                    w_oew_nx   = 1'b1;
                    w_addrw_nx = 16'(WBASE) + {12'b0, r_cnt};
                end
            end
            S_TAP: begin
                w_busy_nx  = 1'b1;
                w_ioe_nx   = w_inb;
                w_iaddr_nx = w_inb ? {w_nrow, w_ncol} : '0;
            end
            S_ACC: w_busy_nx = 1'b1;
            S_WR: begin
                w_busy_nx  = 1'b1;
                w_wen0_nx  = 1'b1;
                w_addr0_nx = {w_row, w_col};
                w_data0_nx = w_clip;
                if (r_sub == 2'd3) begin
                    w_wen1_nx  = 1'b1;
                    w_addr1_nx = {r_prow, r_pcol};
                    w_data1_nx = w_l1_data;
                end
            end
            S_DONE: w_done_nx = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy        <= 1'b0;
            done        <= 1'b0;
            ioe         <= 1'b0;
            iaddr       <= '0;
            oe_weight   <= 1'b0;
            addr_weight <= '0;
            wen_L0      <= 1'b0;
            addr_L0     <= '0;
            w_data_L0   <= '0;
            wen_L1      <= 1'b0;
            addr_L1     <= '0;
            w_data_L1   <= '0;
            r_wk1       <= '0;
            r_tk1       <= '0;
        end else begin
            busy        <= w_busy_nx;
            done        <= w_done_nx;
            ioe         <= w_ioe_nx;
            iaddr       <= w_iaddr_nx;
            oe_weight   <= w_oew_nx;
            addr_weight <= w_addrw_nx;
            wen_L0      <= w_wen0_nx;
            addr_L0     <= w_addr0_nx;
            w_data_L0   <= w_data0_nx;
            wen_L1      <= w_wen1_nx;
            addr_L1     <= w_addr1_nx;
            w_data_L1   <= w_data1_nx;
            r_wk1       <= r_cnt;
            r_tk1       <= r_cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt  <= '0;
            r_prow <= '0;
            r_pcol <= '0;
            r_sub  <= '0;
            r_avg  <= 1'b0;
            r_acc  <= '0;
            r_pool <= '0;
            r_wk2  <= '0;
            r_wv2  <= 1'b0;
            r_tk2  <= '0;
            r_tv   <= 1'b0;
            for (int unsigned i = 0; i < 10; i++)
                r_w[i] <= '0;
        end else begin
            r_wv2 <= oe_weight;
            r_wk2 <= r_wk1;
            r_tv  <= ioe;
            r_tk2 <= r_tk1;
            if (r_wv2)
                r_w[r_wk2] <= r_data_weight;
            if (r_tv)
                r_acc <= r_acc + w_tap_add;
            case (r_state)
                S_IDLE: if (ready) begin
                    r_avg  <= pool_avg;
                    r_cnt  <= '0;
                    r_prow <= '0;
                    r_pcol <= '0;
                    r_sub  <= '0;
                    r_acc  <= '0;
                    r_pool <= '0;
                end
                S_LOADK: r_cnt <= (r_cnt == 4'd10) ? 4'd0 : r_cnt + 4'd1;
                S_TAP:   r_cnt <= (r_cnt == 4'd8) ? 4'd0 : r_cnt + 4'd1;
                S_WR: begin
                    r_acc  <= '0;
                    r_pool <= (r_sub == 2'd3) ? '0 : w_pool_nx;
                    r_sub  <= r_sub + 2'd1;
                    if (r_sub == 2'd3) begin
                        r_pcol <= r_pcol + PCW'(1);
                        if (r_pcol == PCW'(IMG_W/2 - 1))
                            r_prow <= r_prow + PRW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/conv_pool_engine.md
Name: conv_pool_engine

Overview:
Parametrised successor to the fixed-kernel layer-0/layer-1 datapath. It runs a programmable signed 3x3 convolution with bias, arithmetic shift, ReLU and saturation over a gray image of configurable size. It also performs a selectable 2x2/stride-2 pooling (max or average). It reads from the gray-image and weight memories and writes conv results to the L0 memory and pooled results to the L1 memory, under a ready/busy/done handshake.

Parameters:
IMG_W, 128, image width in pixels; power of 2, even, >=4
IMG_H, 128, image height in pixels; even, >=4
PIX_W, 8, unsigned input pixel width
WT_W, 8, signed kernel/bias word width
OUT_W, 12, unsigned L0/L1 data width
ACC_W, 24, signed accumulator width
SHIFT, 0, arithmetic right shift applied after bias add
WBASE, 0, weight-memory address of kernel tap 0

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
ready  in  1  start request, sampled in IDLE
pool_avg  in  1  pooling mode, sampled with ready: 0=max, 1=average
busy  out  1  high while processing
done  out  1  one-cycle pulse at completion
iaddr  out  log2(IMG_W*IMG_H)  image address, {row,col}
ioe  out  1  image read enable
idata  in  PIX_W  image data, valid the cycle after ioe
oe_weight  out  1  weight read enable
addr_weight  out  16  weight address
r_data_weight  in  WT_W  signed weight, valid the cycle after oe_weight
wen_L0  out  1  L0 write strobe
addr_L0  out  log2(IMG_W*IMG_H)  L0 address, {row,col}
w_data_L0  out  OUT_W  conv+ReLU result
wen_L1  out  1  L1 write strobe
addr_L1  out  log2(IMG_W*IMG_H/4)  L1 address, {prow,pcol}
w_data_L1  out  OUT_W  pooled result

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high, named reset. All outputs are registered.
- Reset values: busy, done, ioe, oe_weight, wen_L0 and wen_L1 are 0. All addresses and data outputs are 0. The FSM goes to IDLE.
- Reset mid-operation: returns to IDLE on the next edge. No further writes are issued and the kernel registers are cleared.
- FSM states: IDLE -> LOADK -> TAP -> ACC -> WR -> (TAP | DONE) -> IDLE.
- IDLE: when ready=1, latch pool_avg, set busy=1 and go to LOADK. Otherwise stay.
- LOADK: 11 cycles. Addresses WBASE+0..WBASE+9 are issued with oe_weight=1 on cycles 0..9, and data is captured one cycle later. Taps k=0..8 are the kernel in row-major order (k = 3*(dy+1)+(dx+1)); word 9 is the bias.
- Traversal order: pool blocks in row-major order (prow, pcol). Within each block, pixels are visited in the order (2p,2q), (2p,2q+1), (2p+1,2q), (2p+1,2q+1).
- TAP: 9 cycles per pixel, k=0..8, accessing neighbour (r+dy, c+dx).
  - If the neighbour is out of bounds (zero padding), ioe=0 and its contribution is 0.
  - Otherwise ioe=1 and iaddr={r+dy, c+dx}.
  - The product idata*w[k] (unsigned*signed, sign-correct) is added into the accumulator one cycle later.
- ACC: 1 cycle. Accumulate the last tap.
- WR: 1 cycle.
  - Compute v = (acc + sign-extended bias) >>> SHIFT.
  - Output is 0 if v<0, (2^OUT_W)-1 if v exceeds it, else v.
  - Pulse wen_L0 with addr_L0={r,c}.
  - Update the pool register: running max, or a running sum of width OUT_W+2.
  - On the 4th pixel of a block, pulse wen_L1 in the same cycle with addr_L1={prow,pcol}. w_data_L1 is the max, or sum>>2 (truncating).
  - Then clear the accumulator and pool register.
- Timing: exactly 11 cycles per pixel, first TAP cycle to WR inclusive. After the last pixel's WR, the FSM enters DONE: done=1 and busy=0 for 1 cycle, then IDLE.
- Total latency from ready being sampled to done: 11 + 11*IMG_W*IMG_H + 1 cycles.
- ready while busy is ignored. The kernel is reloaded on every start.
- Accumulator width: ACC_W must hold 9*(2^PIX_W-1)*2^(WT_W-1) plus the bias. No wrap is permitted at the default parameters.
- Edge rows and columns use zero padding. The four corner pixels have 4 valid taps, edge pixels have 6, interior pixels have 9.

Test Plan:
- IMG_W=IMG_H=4, image = 0..15, kernel = centre 1 and others 0, bias 0, max mode -> L0 equals the image; L1 = {5,7,13,15}. done arrives 11+176+1 cycles after ready.
- Same image and kernel, average mode -> L1 = {2,4,10,12}, i.e. (0+1+4+5)>>2 = 2, etc.
- All pixels 255, all taps +8 -> every L0 = 4095 (corner sum 8160 saturates); L1 = 4095.
- All pixels 200, all taps -1, bias +5 -> all L0 = 0 (ReLU); L1 = 0 in both modes.
- Zero kernel, bias +100 -> every L0 = 100; L1 = 100. Padded taps must assert ioe=0; check corner pixel (0,0) issues exactly 4 image reads.
- Assert reset during the TAP of pixel 5, then ready -> no writes after reset; a fresh run reproduces the first scenario's results exactly. A ready pulse during busy has no effect.
